axi4_lite_reg_file: RTL and testbench

- AXI4-Lite slave exposing a bank of 2**CLOG2_W registers, each N bytes wide.
- Written values are held internally and driven out on register_out.
- Reads return register_in, so the surrounding logic can loop back, override or supply live status.
- Sits behind an AXI4-Lite interconnect as the control/status block of a peripheral.

---
 rtl/axi4_lite_pkg.sv | 15 +
 rtl/axi4_lite_reg_file_wr_ctrl.sv | 71 +++++++
 rtl/axi4_lite_reg_file.sv | 102 ++++++++++
 tb/tb_axi4_lite_reg_file.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared AXI4-Lite configuration type, derived widths and response codes.
package axi4_lite_pkg;
    typedef struct packed {
        int unsigned a;
        int unsigned n;
    } axi_cfg_t;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    function automatic int unsigned data_w(axi_cfg_t c);
        return 8 * c.n;
    endfunction
    function automatic int unsigned off_w(axi_cfg_t c);
        return $clog2(c.n);
    endfunction
endpackage

// File: rtl/axi4_lite_reg_file_wr_ctrl.sv
// axi4_lite_reg_file_wr_ctrl: independent AW/W capture, write commit strobe and B response.
module axi4_lite_reg_file_wr_ctrl
    import axi4_lite_pkg::*;
#(
    parameter int A = 16,
    parameter int N = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [A-1:0]   awaddr_i,
    input  logic           awvalid_i,
    output logic           awready_o,
    input  logic [8*N-1:0] wdata_i,
    input  logic [N-1:0]   wstrb_i,
    input  logic           wvalid_i,
    output logic           wready_o,
    output logic [1:0]     bresp_o,
    output logic           bvalid_o,
    input  logic           bready_i,
    output logic           commit_o,
    output logic [A-1:0]   commit_addr_o,
    output logic [8*N-1:0] commit_data_o,
    output logic [N-1:0]   commit_strb_o
);
    logic           aw_held_q, aw_held_d, w_held_q, w_held_d, bvalid_q, bvalid_d;
    logic [A-1:0]   awaddr_q, awaddr_d;
    logic [8*N-1:0] wdata_q, wdata_d;
    logic [N-1:0]   wstrb_q, wstrb_d;
    logic           aw_hs, w_hs, aw_avail, w_avail;

    assign awready_o = !rst_i && !aw_held_q && !bvalid_q;
    assign wready_o  = !rst_i && !w_held_q && !bvalid_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = OKAY;

    // A channel is "available" if already held or handshaking this cycle.
    always_comb begin
        aw_hs         = awvalid_i && awready_o;
        w_hs          = wvalid_i && wready_o;
        aw_avail      = aw_held_q || aw_hs;
        w_avail       = w_held_q || w_hs;
        commit_o      = aw_avail && w_avail;
        awaddr_d      = aw_hs ? awaddr_i : awaddr_q;
        wdata_d       = w_hs ? wdata_i : wdata_q;
        wstrb_d       = w_hs ? wstrb_i : wstrb_q;
        aw_held_d     = aw_avail && !commit_o;
        w_held_d      = w_avail && !commit_o;
        bvalid_d      = commit_o || (bvalid_q && !bready_i);
        commit_addr_o = awaddr_d;
        commit_data_o = wdata_d;
        commit_strb_o = wstrb_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bvalid_q  <= bvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end
endmodule

// File: rtl/axi4_lite_reg_file.sv
// axi4_lite_reg_file: AXI4-Lite register bank; writes drive register_out, reads return register_in.
module axi4_lite_reg_file
    import axi4_lite_pkg::*;
#(
    parameter int A       = 16,
    parameter int N       = 4,
    parameter int CLOG2_W = 4
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [A-1:0]                      awaddr,
    input  logic                              awvalid,
    output logic                              awready,
    input  logic [8*N-1:0]                    wdata,
    input  logic [N-1:0]                      wstrb,
    input  logic                              wvalid,
    output logic                              wready,
    output logic [1:0]                        bresp,
    output logic                              bvalid,
    input  logic                              bready,
    input  logic [A-1:0]                      araddr,
    input  logic                              arvalid,
    output logic                              arready,
    output logic [8*N-1:0]                    rdata,
    output logic [1:0]                        rresp,
    output logic                              rvalid,
    input  logic                              rready,
    output logic [2**CLOG2_W-1:0][8*N-1:0]    register_out,
    input  logic [2**CLOG2_W-1:0][8*N-1:0]    register_in,
    output logic [2**CLOG2_W-1:0]             register_wr
);
    localparam axi_cfg_t CFG = '{a: A, n: N};
    localparam int W   = 2**CLOG2_W;
    localparam int DW  = data_w(CFG);
    localparam int OFF = off_w(CFG);

    logic                  commit;
    logic [A-1:0]          commit_addr;
    logic [DW-1:0]         commit_data;
    logic [N-1:0]          commit_strb;
    logic [CLOG2_W-1:0]    widx, ridx;
    logic [W-1:0][DW-1:0]  regs_q, regs_d;
    logic [W-1:0]          wr_q, wr_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d, ar_hs;
    logic                  unused_addr_bits;

    axi4_lite_reg_file_wr_ctrl #(.A(A), .N(N)) u_wr_ctrl (
        .clk_i         (aclk),
        .rst_i         (areset),
        .awaddr_i      (awaddr),
        .awvalid_i     (awvalid),
        .awready_o     (awready),
        .wdata_i       (wdata),
        .wstrb_i       (wstrb),
        .wvalid_i      (wvalid),
        .wready_o      (wready),
        .bresp_o       (bresp),
        .bvalid_o      (bvalid),
        .bready_i      (bready),
        .commit_o      (commit),
        .commit_addr_o (commit_addr),
        .commit_data_o (commit_data),
        .commit_strb_o (commit_strb)
    );

    // Byte offset and bits above the index are dropped, so addresses alias modulo W*N.
    assign widx             = commit_addr[CLOG2_W+OFF-1:OFF];
    assign ridx             = araddr[CLOG2_W+OFF-1:OFF];
    assign unused_addr_bits = ^{commit_addr[A-1:CLOG2_W+OFF], commit_addr[OFF-1:0],
                                araddr[A-1:CLOG2_W+OFF], araddr[OFF-1:0]};
    assign arready          = !areset && !rvalid_q;
    assign rresp            = OKAY;
    assign rvalid           = rvalid_q;
    assign rdata            = rdata_q;
    assign register_out     = regs_q;
    assign register_wr      = wr_q;

    always_comb begin
        ar_hs    = arvalid && arready;
        rvalid_d = ar_hs || (rvalid_q && !rready);
        rdata_d  = ar_hs ? register_in[ridx] : rdata_q;
        regs_d   = regs_q;
        for (int k = 0; k < N; k++)
            if (commit && commit_strb[k]) regs_d[widx][8*k +: 8] = commit_data[8*k +: 8];
        wr_d     = commit ? W'(1) << widx : '0;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            regs_q   <= '0;
            wr_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            wr_q     <= wr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end
endmodule

// File: tb/tb_axi4_lite_reg_file.sv
// tb_axi4_lite_reg_file: scoreboard bench with a register-array reference model and randomized traffic.
module tb_axi4_lite_reg_file;
    logic aclk = 1'b0, areset = 1'b1;
    logic [15:0] awaddr = '0, araddr = '0;
    logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata;
    logic [15:0][31:0] register_out, register_in;
    logic [15:0] register_wr;
    logic [31:0] in_mask = '0;
    int checks = 0, errors = 0;
    logic [31:0] model [16];
    int exp_wr [16];
    int got_wr [16];
    logic [31:0] exp_r [$];
    logic [1:0] exp_b [$];

    always #5 aclk = ~aclk;
    always_comb for (int i = 0; i < 16; i++) register_in[i] = register_out[i] ^ in_mask;

    axi4_lite_reg_file #(.A(16), .N(4), .CLOG2_W(4)) dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .register_out(register_out), .register_in(register_in), .register_wr(register_wr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    task automatic check_regs();
        for (int i = 0; i < 16; i++) chk($sformatf("register_out[%0d]", i), register_out[i], model[i]);
    endtask

    // Monitor: pops the scoreboard whenever a response handshake is presented.
    always @(negedge aclk) if (!areset) begin
        if (bvalid && bready) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_b: got response expected none");
            end else chk("bresp", 32'(bresp), 32'(exp_b.pop_front()));
        end
        if (rvalid && rready) begin
            if (exp_r.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_r: got rdata %h expected none", rdata);
            end else begin
                chk("rdata", rdata, exp_r.pop_front());
                chk("rresp", 32'(rresp), 32'(2'b00));
            end
        end
        for (int i = 0; i < 16; i++) if (register_wr[i]) got_wr[i]++;
    end

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input int b_wait);
        int idx = int'(addr[5:2]);
        int cyc = 0;
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
        exp_b.push_back(2'b00);
        exp_wr[idx]++;
        awaddr = addr; wdata = data; wstrb = strb; bready = (b_wait == 0);
        while (!(aw_done && w_done)) begin
            awvalid = !aw_done && (lead <= 0 || cyc >= lead);
            wvalid  = !w_done && (lead >= 0 || cyc >= -lead);
            @(negedge aclk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            if (aw_done && !w_done) chk("awready_low_while_held", 32'(awready), 0);
            if (w_done && !aw_done) chk("wready_low_while_held", 32'(wready), 0);
            @(posedge aclk); #1;
            aw_done |= aw_hs;
            w_done  |= w_hs;
            cyc++;
            if (cyc > 50) begin fail("write_handshake"); break; end
        end
        awvalid = 0; wvalid = 0;
        @(negedge aclk);
        chk("bvalid_latency", 32'(bvalid), 1);
        chk("register_wr_pulse", 32'(register_wr), 32'(16'(1) << idx));
        chk("register_out_write", register_out[idx], model[idx]);
        for (int i = 0; i < b_wait; i++) begin
            chk("bvalid_hold", 32'(bvalid), 1);
            chk("awready_during_b", 32'(awready), 0);
            chk("wready_during_b", 32'(wready), 0);
            @(negedge aclk);
        end
        @(posedge aclk); #1;
        bready = 1;
        cyc = 0;
        while (bvalid) begin
            @(negedge aclk);
            if (++cyc > 50) begin fail("b_handshake"); break; end
        end
        @(posedge aclk); #1;
    endtask

    task automatic axi_read(input logic [15:0] addr, input int r_wait);
        int idx = int'(addr[5:2]);
        int cyc = 0;
        bit hs = 0;
        logic [31:0] exp = model[idx] ^ in_mask;
        exp_r.push_back(exp);
        araddr = addr; rready = (r_wait == 0);
        while (!hs) begin
            arvalid = 1;
            @(negedge aclk);
            hs = arready;
            @(posedge aclk); #1;
            if (++cyc > 50) begin fail("ar_handshake"); break; end
        end
        arvalid = 0;
        @(negedge aclk);
        chk("rvalid_latency", 32'(rvalid), 1);
        for (int i = 0; i < r_wait; i++) begin
            chk("rvalid_hold", 32'(rvalid), 1);
            chk("rdata_stable", rdata, exp);
            chk("arready_low_while_rvalid", 32'(arready), 0);
            @(negedge aclk);
        end
        @(posedge aclk); #1;
        rready = 1;
        cyc = 0;
        while (rvalid) begin
            @(negedge aclk);
            if (++cyc > 50) begin fail("r_handshake"); break; end
        end
        @(posedge aclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin model[i] = '0; exp_wr[i] = 0; got_wr[i] = 0; end
        @(negedge aclk);
        chk("reset_awready", 32'(awready), 0);
        chk("reset_wready", 32'(wready), 0);
        chk("reset_arready", 32'(arready), 0);
        chk("reset_bvalid", 32'(bvalid), 0);
        chk("reset_rvalid", 32'(rvalid), 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_register_wr", 32'(register_wr), 0);
        check_regs();
        @(posedge aclk); #1;
        areset = 0;

        axi_read(16'h0004, 0);
        axi_write(16'h0004, 32'hABBA_BEEF, 4'hF, 0, 0);
        chk("full_write", register_out[1], 32'hABBA_BEEF);
        axi_read(16'h0004, 0);
        axi_write(16'h0004, 32'h1122_3344, 4'b0101, 0, 0);
        chk("partial_strobe", register_out[1], 32'hAB22_BE44);
        axi_write(16'h0008, 32'hDEAD_0001, 4'hF, 3, 5);
        axi_write(16'h000C, 32'h0BAD_F00D, 4'hF, -2, 0);
        axi_write(16'h0044, 32'h1234_5678, 4'hF, 0, 0);
        chk("alias_write", register_out[1], 32'h1234_5678);
        check_regs();
        in_mask = 32'hFFFF_0000;
        axi_read(16'h003C, 3);
        axi_read(16'h0004, 1);
        in_mask = '0;

        // Read and write of the same register in the same cycle return the pre-write value.
        exp_r.push_back(model[2] ^ in_mask);
        awaddr = 16'h0008; wdata = 32'h5A5A_0F0F; wstrb = 4'hF; araddr = 16'h0008;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
        @(negedge aclk);
        chk("concurrent_ready", 32'({awready, wready, arready}), 32'(3'b111));
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        model[2] = 32'h5A5A_0F0F;
        exp_b.push_back(2'b00);
        exp_wr[2]++;
        @(negedge aclk);
        chk("concurrent_bvalid", 32'(bvalid), 1);
        chk("concurrent_rvalid", 32'(rvalid), 1);
        @(posedge aclk); #1;
        check_regs();

        for (int n = 0; n < 60; n++) begin
            in_mask = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            if ($urandom_range(0, 1) == 1)
                axi_write(16'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                          int'($urandom_range(0, 2)));
            else
                axi_read(16'($urandom), int'($urandom_range(0, 2)));
        end
        in_mask = '0;
        check_regs();

        // Abort a read that is waiting on rready by asserting reset.
        axi_write(16'h0004, 32'hCAFE_F00D, 4'hF, 0, 0);
        araddr = 16'h0004; rready = 0; arvalid = 1;
        @(posedge aclk); #1;
        arvalid = 0;
        @(negedge aclk);
        chk("rvalid_before_reset", 32'(rvalid), 1);
        @(posedge aclk); #1;
        areset = 1;
        @(negedge aclk);
        chk("mid_reset_awready", 32'(awready), 0);
        chk("mid_reset_arready", 32'(arready), 0);
        @(posedge aclk); #1;
        for (int i = 0; i < 16; i++) model[i] = '0;
        chk("abort_rvalid", 32'(rvalid), 0);
        chk("abort_bvalid", 32'(bvalid), 0);
        check_regs();
        areset = 0; rready = 1;
        axi_read(16'h0004, 0);

        repeat (3) @(posedge aclk);
        chk("pending_b", exp_b.size(), 0);
        chk("pending_r", exp_r.size(), 0);
        for (int i = 0; i < 16; i++) chk($sformatf("register_wr_count[%0d]", i), got_wr[i], exp_wr[i]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
